response_encoder: RTL and testbench

- UART response transmitter: the return path for the command decoder.
- After each decoded command completes, the control logic pulses i_start with the result.
- The block frames a response packet (header byte, plus 4 data bytes for a successful read) and serialises it as 8N1 UART, LSB first, on serial_out.
- Internal bit-level serialiser; no external uart_tx instance.

---
 rtl/response_encoder.sv | 195 +++++++++++++++++++
 tb/tb_response_encoder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/response_encoder.sv
// ============================================================================
// Module   : response_encoder
// Brief    : Frames a command response (header + optional 4 read-data bytes)
//            and serialises it as back-to-back 8N1 UART frames.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module response_encoder #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_start,
    input  logic [1:0]  i_error,
    input  logic        i_readwrite,
    input  logic [31:0] i_data,
    output logic        serial_out,
    output logic        o_busy,
    output logic        o_done
);

    localparam int                  c_baud_w    = $clog2(CLKS_PER_BIT);
    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [c_baud_w-1:0] c_baud_one  = c_baud_w'(1);

    // S_NEXT is folded into the stop-bit terminal cycle and is never entered.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4,
        S_NEXT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [c_baud_w-1:0] baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [2:0]          idx_q, idx_d;
    logic [2:0]          len_q, len_d;
    logic [1:0]          err_q, err_d;
    logic                rw_q, rw_d;
    logic [31:0]         data_q, data_d;
    logic [7:0]          shift_q, shift_d;
    logic                serial_q, serial_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                w_baud_end;
    logic [2:0]          w_idx_next;

    function automatic logic [7:0] sel_byte(input logic [2:0]  idx,
                                            input logic        rw,
                                            input logic [1:0]  err,
                                            input logic [31:0] data);
        case (idx)
            3'd1:    sel_byte = data[7:0];
            3'd2:    sel_byte = data[15:8];
            3'd3:    sel_byte = data[23:16];
            3'd4:    sel_byte = data[31:24];
            default: sel_byte = {4'hA, 1'b0, rw, err};
        endcase
    endfunction

    assign w_baud_end = (baud_q == c_baud_last);
    assign w_idx_next = idx_q + 3'd1;

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        idx_d    = idx_q;
        len_d    = len_q;
        err_d    = err_q;
        rw_d     = rw_q;
        data_d   = data_q;
        shift_d  = shift_q;
        serial_d = serial_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                serial_d = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
                if (i_start) begin
                    err_d   = i_error;
                    rw_d    = i_readwrite;
                    data_d  = i_data;
                    len_d   = (i_readwrite && (i_error == 2'b00)) ? 3'd5 : 3'd1;
                    idx_d   = 3'd0;
                    bit_d   = 3'd0;
                    baud_d  = '0;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                shift_d  = sel_byte(idx_q, rw_q, err_q, data_q);
                serial_d = 1'b0;
                baud_d   = '0;
                state_d  = S_START;
            end
            S_START: begin
                if (w_baud_end) begin
                    baud_d   = '0;
                    bit_d    = 3'd0;
                    serial_d = shift_q[0];
                    state_d  = S_DATA;
                end else begin
                    baud_d = baud_q + c_baud_one;
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    baud_d = '0;
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        serial_d = 1'b1;
                        state_d  = S_STOP;
                    end else begin
                        shift_d  = {1'b0, shift_q[7:1]};
                        serial_d = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + c_baud_one;
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    baud_d = '0;
                    // Next start bit follows the stop bit with no idle gap.
                    if (w_idx_next < len_q) begin
                        idx_d    = w_idx_next;
                        shift_d  = sel_byte(w_idx_next, rw_q, err_q, data_q);
                        serial_d = 1'b0;
                        state_d  = S_START;
                    end else begin
                        serial_d = 1'b1;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end
                end else begin
                    baud_d = baud_q + c_baud_one;
                end
            end
            default: begin
                serial_d = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            idx_q    <= 3'd0;
            len_q    <= 3'd0;
            err_q    <= 2'b00;
            rw_q     <= 1'b0;
            data_q   <= 32'd0;
            shift_q  <= 8'd0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            err_q    <= err_d;
            rw_q     <= rw_d;
            data_q   <= data_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign serial_out = serial_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_response_encoder.sv
// ============================================================================
// Module   : tb_response_encoder
// Brief    : Directed self-checking bench for response_encoder (CLKS_PER_BIT=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_response_encoder;

    localparam int CPB = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_start;
    logic [1:0]  i_error;
    logic        i_readwrite;
    logic [31:0] i_data;
    wire         serial_out;
    wire         o_busy;
    wire         o_done;

    int n_vec  = 0;
    int n_fail = 0;

    logic        chain;
    logic [1:0]  nx_err;
    logic        nx_rw;
    logic [31:0] nx_data;

    response_encoder #(.CLKS_PER_BIT(CPB)) u_dut (
        .clock       (clock),
        .reset       (reset),
        .i_start     (i_start),
        .i_error     (i_error),
        .i_readwrite (i_readwrite),
        .i_data      (i_data),
        .serial_out  (serial_out),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic idle_check(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clock); #1;
            check("idle_line", serial_out, 1);
            check("idle_busy", o_busy, 0);
            check("idle_done", o_done, 0);
        end
    endtask

    // Expected line: per byte, start 0, 8 bits LSB first, stop 1, each CPB cycles.
    task automatic run_packet(input logic [1:0]  err,
                              input logic        rw,
                              input logic [31:0] data,
                              input logic [7:0]  exp_hdr,
                              input int          exp_n,
                              input bit          pre,
                              input int          inject_cyc,
                              input int          abort_cyc);
        logic [7:0] b;
        logic [9:0] frame;
        int         cyc;
        bit         aborted;
        aborted = 1'b0;
        if (!pre) begin
            @(negedge clock);
            i_start     = 1'b1;
            i_error     = err;
            i_readwrite = rw;
            i_data      = data;
        end
        @(posedge clock); #1;
        i_start     = 1'b0;
        i_error     = ~err;
        i_readwrite = ~rw;
        i_data      = ~data;
        check("accept_busy", o_busy, 1);
        check("accept_line", serial_out, 1);
        check("accept_done", o_done, 0);
        cyc = 0;
        for (int k = 0; k < exp_n && !aborted; k++) begin
            b     = (k == 0) ? exp_hdr : data[8*(k-1) +: 8];
            frame = {1'b1, b, 1'b0};
            for (int p = 0; p < 10*CPB && !aborted; p++) begin
                @(posedge clock); #1;
                i_start = 1'b0;
                check("line", serial_out, frame[p/CPB]);
                check("busy", o_busy, 1);
                check("done_early", o_done, 0);
                if (cyc == inject_cyc) begin
                    i_start     = 1'b1;
                    i_error     = 2'b00;
                    i_readwrite = 1'b1;
                    i_data      = 32'hDEADBEEF;
                end
                if (cyc == abort_cyc) begin
                    reset   = 1'b1;
                    aborted = 1'b1;
                end
                cyc++;
            end
        end
        if (aborted) begin
            @(posedge clock); #1;
            reset = 1'b0;
            check("abort_line", serial_out, 1);
            check("abort_busy", o_busy, 0);
            check("abort_done", o_done, 0);
            idle_check(12*CPB);
        end else begin
            @(posedge clock); #1;
            check("done", o_done, 1);
            check("done_busy", o_busy, 0);
            check("done_line", serial_out, 1);
            if (chain) begin
                chain       = 1'b0;
                i_start     = 1'b1;
                i_error     = nx_err;
                i_readwrite = nx_rw;
                i_data      = nx_data;
            end else begin
                @(posedge clock); #1;
                check("done_pulse", o_done, 0);
                check("after_busy", o_busy, 0);
                idle_check(12*CPB);
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        i_start     = 1'b0;
        i_error     = 2'b00;
        i_readwrite = 1'b0;
        i_data      = 32'd0;
        chain       = 1'b0;
        nx_err      = 2'b00;
        nx_rw       = 1'b0;
        nx_data     = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_line", serial_out, 1);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        reset = 1'b0;
        idle_check(4);

        // Write acknowledge, ok: header A0 only.
        run_packet(2'b00, 1'b0, 32'h0000_0000, 8'hA0, 1, 1'b0, -1, -1);
        // Read ok with a stray start and data change during byte 1.
        run_packet(2'b00, 1'b1, 32'h1234_5678, 8'hA4, 5, 1'b0, 60, -1);
        // Read with errors: header only, data suppressed.
        run_packet(2'b10, 1'b1, 32'hFFFF_FFFF, 8'hA6, 1, 1'b0, -1, -1);
        run_packet(2'b01, 1'b1, 32'h8000_0001, 8'hA5, 1, 1'b0, -1, -1);
        run_packet(2'b11, 1'b0, 32'h5555_AAAA, 8'hA3, 1, 1'b0, -1, -1);
        // Reset during bit 3 of byte 2 (cycle 97 of line time), then a fresh packet.
        run_packet(2'b00, 1'b1, 32'h1234_5678, 8'hA4, 5, 1'b0, -1, 97);
        run_packet(2'b00, 1'b1, 32'hCAFE_F00D, 8'hA4, 5, 1'b0, -1, -1);
        // New request accepted in the o_done cycle of the previous packet.
        chain   = 1'b1;
        nx_err  = 2'b00;
        nx_rw   = 1'b1;
        nx_data = 32'hA5C3_0F81;
        run_packet(2'b01, 1'b0, 32'h0000_0000, 8'hA1, 1, 1'b0, -1, -1);
        run_packet(2'b00, 1'b1, 32'hA5C3_0F81, 8'hA4, 5, 1'b1, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
